// File: rtl/bit_stream_tx.sv
// Programmable-rate NRZ serializer: valid/ready word intake, alternating preamble
// on each burst start, MSB-first data, every bit exactly max(bit_period,2) cycles.
module bit_stream_tx #(
  parameter int DATA_W        = 8,
  parameter int PERIOD_W      = 16,
  parameter int PREAMBLE_BITS = 16
) (
  input  logic                clk_200M,
  input  logic                rst_n,
  input  logic [PERIOD_W-1:0] bit_period,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                signal,
  output logic                bit_strobe,
  output logic                busy
);

  localparam int PRE_W = (PREAMBLE_BITS > 0) ? $clog2(PREAMBLE_BITS + 1) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(DATA_W - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_MIN = PERIOD_W'(2);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PREAMBLE = 2'd1;
  localparam logic [1:0] DATA     = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                signal_q, signal_d;

  logic bit_end;
  logic load_hold;
  logic bypass;
  logic transfer;

  assign data_ready = !hold_full_q;
  assign transfer   = data_valid && !hold_full_q;
  assign signal     = signal_q;
  assign busy       = (state_q != IDLE);
  assign bit_strobe = busy && (cnt_q == '0);
  assign bit_end    = (cnt_q == period_q - PERIOD_W'(1));

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    period_d    = period_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pre_d       = pre_q;
    signal_d    = signal_q;
    load_hold   = 1'b0;
    bypass      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        signal_d = 1'b0;
        if (hold_full_q) begin
          period_d = (bit_period < PERIOD_MIN) ? PERIOD_MIN : bit_period;
          if (PREAMBLE_BITS > 0) begin
            state_d  = PREAMBLE;
            pre_d    = '0;
            signal_d = 1'b1;
          end else begin
            state_d   = DATA;
            load_hold = 1'b1;
          end
        end
      end
      PREAMBLE: begin
        cnt_d = bit_end ? '0 : cnt_q + PERIOD_W'(1);
        if (bit_end) begin
          if (pre_q == PRE_LAST) begin
            state_d   = DATA;
            load_hold = 1'b1;
          end else begin
            pre_d    = pre_q + PRE_W'(1);
            signal_d = !signal_q;
          end
        end
      end
      DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + PERIOD_W'(1);
        if (bit_end) begin
          if (idx_q != IDX_LAST) begin
            shift_d  = shift_q << 1;
            signal_d = shift_d[DATA_W-1];
            idx_d    = idx_q + IDX_W'(1);
          end else if (hold_full_q) begin
            load_hold = 1'b1;
          end else if (data_valid) begin
            // Word arriving right at the LSB boundary skips the hold register
            bypass   = 1'b1;
            shift_d  = data_in;
            signal_d = data_in[DATA_W-1];
            idx_d    = '0;
          end else begin
            state_d  = IDLE;
            signal_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        signal_d = 1'b0;
        cnt_d    = '0;
      end
    endcase

    if (load_hold) begin
      shift_d     = hold_q;
      signal_d    = hold_q[DATA_W-1];
      idx_d       = '0;
      hold_full_d = 1'b0;
    end

    if (transfer && !bypass) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      period_q    <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      pre_q       <= '0;
      signal_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pre_q       <= pre_d;
      signal_q    <= signal_d;
    end
  end

endmodule

// File: tb/tb_bit_stream_tx.sv
// Scoreboard bench for bit_stream_tx: stimulus queues expected bits and periods,
// a monitor pops one entry per bit_strobe and checks value, length and stability.
`timescale 1ns/1ps
module tb_bit_stream_tx;

  localparam int PRE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bit_period = 16'd4;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
  logic        data_ready, signal, bit_strobe, busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic exp_bit_q[$];
  int   exp_per_q[$];

  bit_stream_tx #(.DATA_W(8), .PERIOD_W(16), .PREAMBLE_BITS(PRE)) dut (
    .clk_200M  (clk),
    .rst_n     (rst_n),
    .bit_period(bit_period),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .signal    (signal),
    .bit_strobe(bit_strobe),
    .busy      (busy)
  );

  always #2.5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic push_word(input logic [7:0] w, input int per, input bit with_pre);
    if (with_pre)
      for (int i = 0; i < PRE; i++) begin
        exp_bit_q.push_back(logic'((i % 2) == 0));
        exp_per_q.push_back(per);
      end
    for (int i = 7; i >= 0; i--) begin
      exp_bit_q.push_back(w[i]);
      exp_per_q.push_back(per);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge, valid still high.
  task automatic offer(input logic [7:0] w);
    bit got = 1'b0;
    data_in    = w;
    data_valid = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if (data_ready) got = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (got) break;
    end
    check("accept", int'(got), 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 5000; i++) begin
      if (!busy && exp_bit_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("queue_drained", exp_bit_q.size(), 0);
    check("idle_line", int'({busy, signal}), 0);
  endtask

  // Monitor: one scoreboard pop per bit_strobe
  initial begin : monitor
    int   cyc = 0, start = 0, cur_per = 0;
    logic cur_bit = 1'b0;
    bit   pending = 1'b0, stable = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 1'b0;
      end else begin
        cyc++;
        if (pending && (bit_strobe || !busy)) begin
          check("bit_len", cyc - start, cur_per);
          check("bit_stable", int'(stable), 1);
          pending = 1'b0;
        end
        if (bit_strobe) begin
          if (exp_bit_q.size() == 0) begin
            check("unexpected_bit", 1, 0);
          end else begin
            cur_bit = exp_bit_q.pop_front();
            cur_per = exp_per_q.pop_front();
            check("bit_value", int'(signal), int'(cur_bit));
            pending = 1'b1;
            start   = cyc;
            stable  = 1'b1;
          end
        end else if (pending && signal !== cur_bit) begin
          stable = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int bc, sc;
    repeat (3) @(negedge clk);
    check("rst_signal", int'(signal), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_strobe", int'(bit_strobe), 0);
    check("rst_ready", int'(data_ready), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Preamble plus 0xA5 at period 4
    bit_period = 16'd4;
    push_word(8'hA5, 4, 1'b1);
    offer(8'hA5);
    data_valid = 1'b0;
    check("lat_busy_low", int'(busy), 0);
    @(negedge clk);
    check("first_busy", int'(busy), 1);
    check("first_signal", int'(signal), 1);
    bc = 1;
    sc = int'(bit_strobe);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
      if (bit_strobe) sc++;
    end
    check("busy_cycles", bc, 48);
    check("strobe_count", sc, 12);
    wait_done();

    // Streaming 0xFF then 0x00, single preamble
    push_word(8'hFF, 4, 1'b1);
    push_word(8'h00, 4, 1'b0);
    offer(8'hFF);
    offer(8'h00);
    check("stream_second_while_busy", int'(busy), 1);
    data_valid = 1'b0;
    wait_done();

    // Bypass: 0x3C offered exactly in the LSB bit_end cycle
    push_word(8'h81, 4, 1'b1);
    push_word(8'h3C, 4, 1'b0);
    offer(8'h81);
    data_valid = 1'b0;
    sc = 0;
    for (int i = 0; i < 200 && sc < 12; i++) begin
      if (bit_strobe) sc++;
      if (sc < 12) @(negedge clk);
    end
    check("bypass_reach_lsb", sc, 12);
    repeat (3) @(negedge clk);
    data_in    = 8'h3C;
    data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    check("bypass_hold_empty", int'(data_ready), 1);
    check("bypass_no_gap", int'({busy, bit_strobe}), 3);
    wait_done();

    // Period clamp: 0 -> 2 cycles per bit
    bit_period = 16'd0;
    push_word(8'h5A, 2, 1'b1);
    offer(8'h5A);
    data_valid = 1'b0;
    wait_done();

    // Period latch: change 4 -> 9 mid-burst, takes effect at next IDLE exit
    bit_period = 16'd4;
    push_word(8'hC3, 4, 1'b1);
    push_word(8'h3A, 4, 1'b0);
    offer(8'hC3);
    data_valid = 1'b0;
    repeat (6) @(negedge clk);
    bit_period = 16'd9;
    offer(8'h3A);
    data_valid = 1'b0;
    wait_done();
    push_word(8'h96, 9, 1'b1);
    offer(8'h96);
    data_valid = 1'b0;
    wait_done();

    // Asynchronous reset mid-DATA with a word waiting in hold
    bit_period = 16'd4;
    push_word(8'hE7, 4, 1'b1);
    offer(8'hE7);
    data_valid = 1'b0;
    offer(8'h11);
    data_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #0.5;
    check("arst_signal", int'(signal), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_ready", int'(data_ready), 1);
    exp_bit_q.delete();
    exp_per_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bc = 0;
    sc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (bit_strobe || signal) sc++;
    end
    check("post_rst_busy", bc, 0);
    check("post_rst_activity", sc, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bit_stream_tx.md
Name: bit_stream_tx

Overview:
Programmable-rate NRZ serializer on the 200 MHz base clock. Produces the `signal` line that our bit clock recovery block consumes, so it serves as both a loopback stimulus source and a real transmitter. Parallel words enter through a valid/ready handshake. Each burst starts with an alternating preamble, which gives the receiver's minimum-interval search a clean lock. Each bit lasts exactly `bit_period` base-clock cycles.

Parameters:
DATA_W, 8, word width; serialized MSB first.
PERIOD_W, 16, width of bit_period and the bit-cycle counter (matches the receiver's clk_freq).
PREAMBLE_BITS, 16, alternating bits sent at burst start (1 first); 0 disables the preamble.

Ports:
clk_200M  input  1  base clock; every register is on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
bit_period  input  PERIOD_W  cycles per bit; sampled only on leaving IDLE.
data_in  input  DATA_W  word to send.
data_valid  input  1  data_in is valid.
data_ready  output  1  holding register is empty; a transfer occurs when data_valid && data_ready at a rising edge.
signal  output  1  serial NRZ line; registered.
bit_strobe  output  1  one-cycle pulse on the first cycle of every bit (preamble and data).
busy  output  1  FSM is not IDLE.

Behaviour:
- Reset values (asserted asynchronously, held while rst_n=0):
  - signal=0, bit_strobe=0, busy=0.
  - Holding register empty, so data_ready=1.
  - FSM=IDLE; counters=0.
- Reset mid-burst aborts at once: no partial-word completion, and hold contents are discarded.
- Holding register (one word):
  - data_ready = !hold_full (combinational).
  - A transfer sets hold_full.
  - Loading the shift register from hold clears hold_full.
- Period latch: period_q = max(bit_period, 2), latched when leaving IDLE. Changes to bit_period during a burst are ignored.
- Bit-cycle counter runs 0..period_q-1.
  - bit_end is true when counter == period_q-1.
  - At bit_end the counter wraps to 0 and the next bit is driven at that edge.
  - bit_strobe is high in the cycle where counter==0 and state != IDLE.
- FSM states and transitions:
  - IDLE: signal=0.
    - If hold_full and PREAMBLE_BITS>0: go to PREAMBLE and drive signal=1 at that edge.
    - If hold_full and PREAMBLE_BITS=0: go to DATA, load shift register from hold, drive its MSB.
  - PREAMBLE: signal toggles at each bit_end. After PREAMBLE_BITS bits, go to DATA at the last bit_end and load from hold (hold_full is guaranteed).
  - DATA: shift left at each bit_end.
    - At bit_end of the LSB, with hold_full: load from hold, stay in DATA, no gap.
    - At bit_end of the LSB, with !hold_full but data_valid high: bypass-load data_in directly (hold stays empty), stay in DATA.
    - Otherwise: go to IDLE and drive signal=0.
- Latency: the transfer is at edge E0; FSM leaves IDLE at E1; the first preamble bit is on signal from E1. Each bit is exactly period_q cycles.
- Back-to-back words have no idle cycles between them. A preamble is sent only on IDLE exit.
- Bit-count and shift widths: the bit index counts 0..DATA_W-1. The preamble counter width is clog2(PREAMBLE_BITS+1). All counters wrap or reset only as stated; none overflows.
- Simultaneous events:
  - A transfer in the same cycle the hold is loaded into the shift register is impossible, because data_ready=0 whenever hold is full.
  - A transfer in the IDLE cycle is seen by the FSM one edge later.

Test Plan:
- Reset: drive rst_n=0 mid-DATA with period 4 -> signal=0, busy=0, data_ready=1 immediately (asynchronous); after release, no residual bits.
- PREAMBLE_BITS=4, bit_period=4, send 0xA5 -> signal=1,0,1,0 then 1,0,1,0,0,1,0,1, each held exactly 4 cycles; first bit 1 cycle after the transfer; busy drops after 48 cycles; 12 bit_strobe pulses.
- Streaming: send 0xFF then 0x00 with data_valid held -> 8 ones then 8 zeros with no gap; second word accepted while the first shifts; only one preamble.
- Bypass: offer 0x3C exactly in the LSB bit_end cycle of the previous word with hold empty -> loaded directly, no preamble, no idle cycle.
- Period clamp and latch: bit_period=0 -> every bit lasts 2 cycles; changing bit_period 4->9 mid-burst -> remains 4 until the next IDLE exit, then 9.
- Loopback: bit_period=8 with continuous random words into the clock recovery receiver -> its clk_freq settles to 8 (±1) within the preamble plus 2 words.
